// File: rtl/rv4028_bus_target.sv
`default_nettype none
// ============================================================================
// Module      : rv4028_bus_target
// Description : 16-bit wait-stated bus target with an internal RAM and four
//               IO registers (gpio out, gpio in, cycle counter, scratch).
// Revision    : 1.0 - initial release
// ============================================================================
module rv4028_bus_target #(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_AW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic [1:0]  msk_n,
    input  logic        iorq_n,
    input  logic        mreq_n,
    output logic        wait_n,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic [15:0] gpio_out,
    input  logic [15:0] gpio_in,
    output logic        err
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_ACK    = 2'd2;
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam int         c_DEPTH     = 1 << MEM_AW;
    localparam int         c_HI_LSB    = MEM_AW + 1;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_op_rd;
    logic              r_op_bad;
    logic              r_io;
    logic              r_oor;
    logic [MEM_AW-1:0] r_idx;
    logic [1:0]        r_reg_sel;
    logic [1:0]        r_msk_n;
    logic [15:0]       r_wdata;
    logic [15:0]       r_mem_q;
    logic [15:0]       r_io_q;
    logic [15:0]       r_data_out;
    logic [15:0]       r_gpio_out;
    logic [15:0]       r_scratch;
    logic [15:0]       r_cycle;
    logic              r_wait_n;
    logic              r_data_oe;
    logic              r_err;
    logic [15:0]       r_mem [0:c_DEPTH-1];

    logic              w_req;
    logic              w_perform;
    logic              w_oor;
    logic              w_mem_we;
    logic [15:0]       w_lane_mask;
    logic [15:0]       w_io_rd;
    logic              w_unused;

    // Both strobes low still starts a (faulty) handshake so the initiator is released.
    assign w_req       = (r_state == c_ST_IDLE) && !mreq_n && (!rd_n || !wr_n);
    assign w_perform   = (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
    assign w_oor       = |(addr[30:0] >> c_HI_LSB);
    assign w_mem_we    = w_perform && !r_op_rd && !r_op_bad && !r_io && !r_oor;
    assign w_lane_mask = {{8{~r_msk_n[1]}}, {8{~r_msk_n[0]}}};
    assign w_unused    = ^{addr[31], addr[0]};

    always_comb begin
        w_io_rd = r_scratch;
        case (addr[2:1])
            2'd0:    w_io_rd = r_gpio_out;
            2'd1:    w_io_rd = gpio_in;
            2'd2:    w_io_rd = r_cycle;
            default: w_io_rd = r_scratch;
        endcase
    end

    // RAM is not reset; read is launched on the request edge so data is ready by ACK.
    always_ff @(posedge clk) begin
        if (w_req) begin
            r_mem_q <= r_mem[addr[MEM_AW:1]];
        end
        if (w_mem_we) begin
            if (!r_msk_n[0]) r_mem[r_idx][7:0]  <= r_wdata[7:0];
            if (!r_msk_n[1]) r_mem[r_idx][15:8] <= r_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 4'd0;
            r_op_rd    <= 1'b0;
            r_op_bad   <= 1'b0;
            r_io       <= 1'b0;
            r_oor      <= 1'b0;
            r_idx      <= '0;
            r_reg_sel  <= 2'd0;
            r_msk_n    <= 2'b11;
            r_wdata    <= 16'h0000;
            r_io_q     <= 16'h0000;
            r_data_out <= 16'h0000;
            r_gpio_out <= 16'h0000;
            r_scratch  <= 16'h0000;
            r_cycle    <= 16'h0000;
            r_wait_n   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 16'd1;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        r_state   <= c_ST_WAIT;
                        r_cnt     <= c_WAIT_LOAD;
                        r_op_rd   <= !rd_n;
                        r_op_bad  <= !rd_n && !wr_n;
                        r_io      <= !iorq_n;
                        r_oor     <= w_oor;
                        r_idx     <= addr[MEM_AW:1];
                        r_reg_sel <= addr[2:1];
                        r_msk_n   <= msk_n;
                        r_wdata   <= data_in;
                        r_io_q    <= w_io_rd;
                    end
                end
                c_ST_WAIT: begin
                    if (w_perform) begin
                        r_state  <= c_ST_ACK;
                        r_wait_n <= 1'b1;
                        if (r_op_bad) begin
                            r_err <= 1'b1;
                        end else if (r_op_rd) begin
                            r_data_oe <= 1'b1;
                            if (r_io) begin
                                r_data_out <= r_io_q;
                            end else if (r_oor) begin
                                r_data_out <= 16'hFFFF;
                                r_err      <= 1'b1;
                            end else begin
                                r_data_out <= r_mem_q;
                            end
                        end else if (r_io) begin
                            if (r_reg_sel == 2'd0)
                                r_gpio_out <= (r_gpio_out & ~w_lane_mask) | (r_wdata & w_lane_mask);
                            if (r_reg_sel == 2'd3)
                                r_scratch <= (r_scratch & ~w_lane_mask) | (r_wdata & w_lane_mask);
                        end else if (r_oor) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_ACK: begin
                    if (mreq_n) begin
                        r_state   <= c_ST_IDLE;
                        r_wait_n  <= 1'b0;
                        r_data_oe <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_wait_n  <= 1'b0;
                    r_data_oe <= 1'b0;
                end
            endcase
        end
    end

    assign wait_n   = r_wait_n;
    assign data_out = r_data_out;
    assign data_oe  = r_data_oe;
    assign gpio_out = r_gpio_out;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rv4028_bus_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv4028_bus_target
// Description : Vector table, directed reset-abort sequence and randomized
//               transactions against a behavioural model of the bus target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv4028_bus_target;

    localparam int WAIT_CYCLES = 2;
    localparam int MEM_AW      = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        wr_n;
    logic        rd_n;
    logic [1:0]  msk_n;
    logic        iorq_n;
    logic        mreq_n;
    logic        wait_n;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] cyc_model;

    typedef struct {
        logic        io;
        logic [31:0] a;
        int          op;      // 0 read, 1 write, 2 both strobes low
        logic [1:0]  m;
        logic [15:0] d;
        logic [15:0] gin;
        logic [15:0] exp_d;
        logic        exp_oe;
        logic        exp_err;
        logic [15:0] exp_gpio;
    } vec_t;

    vec_t vecs[$];

    rv4028_bus_target #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .MEM_AW     (MEM_AW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .msk_n   (msk_n),
        .iorq_n  (iorq_n),
        .mreq_n  (mreq_n),
        .wait_n  (wait_n),
        .data_in (data_in),
        .data_out(data_out),
        .data_oe (data_oe),
        .gpio_out(gpio_out),
        .gpio_in (gpio_in),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Free-running count of clock edges since the last reset.
    always @(posedge clk) begin
        if (rst) cyc_model <= 16'h0000;
        else     cyc_model <= cyc_model + 16'd1;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] m);
        logic [15:0] r;
        r = old_v;
        if (!m[0]) r[7:0]  = new_v[7:0];
        if (!m[1]) r[15:8] = new_v[15:8];
        return r;
    endfunction

    // One full handshake; inputs are scrambled right after the request edge.
    task automatic do_access(input logic io, input logic [31:0] a, input int op,
                             input logic [1:0] m, input logic [15:0] d,
                             output logic [15:0] dout, output logic oe,
                             output logic [15:0] snap);
        int lat;
        iorq_n  = ~io;
        addr    = a;
        msk_n   = m;
        data_in = d;
        rd_n    = !(op == 0 || op == 2);
        wr_n    = !(op == 1 || op == 2);
        mreq_n  = 1'b0;
        snap    = cyc_model;
        @(posedge clk); #1;
        addr    = $urandom;
        data_in = 16'($urandom);
        msk_n   = 2'($urandom);
        iorq_n  = 1'($urandom);
        gpio_in = 16'($urandom);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wait_n) begin
                lat = n;
                break;
            end
        end
        chk("wait_latency", 32'(lat), 32'(WAIT_CYCLES));
        dout = data_out;
        oe   = data_oe;
        @(posedge clk); #1;
        chk("ack_hold_wait_n", {31'd0, wait_n}, 32'd1);
        chk("ack_hold_data", {16'd0, data_out}, {16'd0, dout});
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        @(posedge clk); #1;
        chk("idle_wait_n", {31'd0, wait_n}, 32'd0);
        chk("idle_data_oe", {31'd0, data_oe}, 32'd0);
    endtask

    initial begin
        logic [15:0] dout;
        logic        oe;
        logic [15:0] snap;
        logic [15:0] mdl_mem [int];
        int          pool [8];
        logic [15:0] mdl_gpio;
        logic [15:0] mdl_scratch;
        logic        mdl_err;

        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 1, 2'b00, 16'hA55A, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 0, 2'b00, 16'h0000, 16'h0000, 16'hA55A, 1'b1, 1'b0, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0020, 1, 2'b00, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0020, 1, 2'b10, 16'hFF00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0020, 0, 2'b00, 16'h0000, 16'h0000, 16'h1200, 1'b1, 1'b0, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0000, 1, 2'b00, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0000, 0, 2'b00, 16'h0000, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0002, 1, 2'b00, 16'h1111, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0002, 0, 2'b00, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0006, 1, 2'b01, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0006, 0, 2'b00, 16'h0000, 16'h0000, 16'hAB00, 1'b1, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 1, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 0, 2'b00, 16'h0000, 16'h0000, 16'hA55A, 1'b1, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b0, 32'h8000_0011, 0, 2'b00, 16'h0000, 16'h0000, 16'hA55A, 1'b1, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b0, 32'h0000_07FE, 1, 2'b00, 16'hC0DE, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b0, 32'h0000_07FE, 0, 2'b00, 16'h0000, 16'h0000, 16'hC0DE, 1'b1, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0004, 1, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF});
        vecs.push_back(vec_t'{1'b0, 32'h0000_1000, 0, 2'b00, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'hBEEF});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 2, 2'b00, 16'h7777, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 0, 2'b00, 16'h0000, 16'h0000, 16'hA55A, 1'b1, 1'b1, 16'hBEEF});

        rst = 1'b1; addr = '0; wr_n = 1'b1; rd_n = 1'b1; msk_n = 2'b11;
        iorq_n = 1'b1; mreq_n = 1'b1; data_in = '0; gpio_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wait_n",   {31'd0, wait_n},   32'd0);
        chk("reset_data_oe",  {31'd0, data_oe},  32'd0);
        chk("reset_data_out", {16'd0, data_out}, 32'd0);
        chk("reset_gpio_out", {16'd0, gpio_out}, 32'd0);
        chk("reset_err",      {31'd0, err},      32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            gpio_in = vecs[i].gin;
            do_access(vecs[i].io, vecs[i].a, vecs[i].op, vecs[i].m, vecs[i].d, dout, oe, snap);
            chk($sformatf("vec%0d_data_oe", i), {31'd0, oe}, {31'd0, vecs[i].exp_oe});
            if (vecs[i].exp_oe)
                chk($sformatf("vec%0d_data_out", i), {16'd0, dout}, {16'd0, vecs[i].exp_d});
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_gpio_out", i), {16'd0, gpio_out}, {16'd0, vecs[i].exp_gpio});
        end

        // Reset lands while a write to 0x10 is still counting wait states.
        iorq_n = 1'b1; addr = 32'h10; msk_n = 2'b00; data_in = 16'hD00D;
        wr_n = 1'b0; rd_n = 1'b1; mreq_n = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_wait_n",   {31'd0, wait_n},   32'd0);
        chk("abort_data_oe",  {31'd0, data_oe},  32'd0);
        chk("abort_data_out", {16'd0, data_out}, 32'd0);
        chk("abort_err",      {31'd0, err},      32'd0);
        chk("abort_gpio_out", {16'd0, gpio_out}, 32'd0);
        rst = 1'b0; mreq_n = 1'b1; wr_n = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 32'h10, 0, 2'b00, 16'h0, dout, oe, snap);
        chk("abort_reread_mem", {16'd0, dout}, 32'h0000_A55A);
        do_access(1'b1, 32'h6, 0, 2'b00, 16'h0, dout, oe, snap);
        chk("abort_scratch_cleared", {16'd0, dout}, 32'd0);
        do_access(1'b1, 32'h4, 0, 2'b00, 16'h0, dout, oe, snap);
        chk("cycle_counter_read", {16'd0, dout}, {16'd0, snap});
        chk("abort_err_after", {31'd0, err}, 32'd0);

        mdl_gpio    = 16'h0000;
        mdl_scratch = 16'h0000;
        mdl_err     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            pool[i] = i * 128 + int'($urandom_range(0, 127));
            v = 16'($urandom);
            do_access(1'b0, 32'(pool[i]) << 1, 1, 2'b00, v, dout, oe, snap);
            mdl_mem[pool[i]] = v;
        end

        for (int t = 0; t < 150; t++) begin
            int          r;
            int          op;
            int          idx;
            logic        io;
            logic        oor;
            logic [31:0] a;
            logic [1:0]  m;
            logic [15:0] d;
            logic [15:0] gin;
            logic [15:0] exp_d;
            logic        exp_oe;

            r   = int'($urandom_range(0, 99));
            op  = (r < 5) ? 2 : int'($urandom_range(0, 1));
            io  = (r >= 5 && r < 35);
            m   = 2'($urandom);
            d   = 16'($urandom);
            gin = 16'($urandom);
            oor = 1'b0;
            idx = pool[$urandom_range(0, 7)];
            if (io) begin
                a = $urandom;
            end else begin
                a = (32'(idx) << 1) | ($urandom & 32'h8000_0001);
                if ($urandom_range(0, 9) == 0) begin
                    a   = a | (32'h1 << $urandom_range(MEM_AW + 1, 30));
                    oor = 1'b1;
                end
            end
            gpio_in = gin;
            do_access(io, a, op, m, d, dout, oe, snap);

            exp_d  = 16'h0000;
            exp_oe = (op == 0);
            if (op == 2) begin
                mdl_err = 1'b1;
            end else if (io) begin
                if (op == 0) begin
                    case (a[2:1])
                        2'd0: exp_d = mdl_gpio;
                        2'd1: exp_d = gin;
                        2'd2: exp_d = snap;
                        default: exp_d = mdl_scratch;
                    endcase
                end else begin
                    if (a[2:1] == 2'd0) mdl_gpio    = merge(mdl_gpio, d, m);
                    if (a[2:1] == 2'd3) mdl_scratch = merge(mdl_scratch, d, m);
                end
            end else if (oor) begin
                mdl_err = 1'b1;
                exp_d   = 16'hFFFF;
            end else if (op == 0) begin
                exp_d = mdl_mem[idx];
            end else begin
                mdl_mem[idx] = merge(mdl_mem[idx], d, m);
            end

            chk($sformatf("rnd%0d_data_oe", t), {31'd0, oe}, {31'd0, exp_oe});
            if (exp_oe)
                chk($sformatf("rnd%0d_data_out", t), {16'd0, dout}, {16'd0, exp_d});
            chk($sformatf("rnd%0d_err", t), {31'd0, err}, {31'd0, mdl_err});
            chk($sformatf("rnd%0d_gpio_out", t), {16'd0, gpio_out}, {16'd0, mdl_gpio});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
